fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the control unit.

---
 rtl/fetch_stage.sv | 183 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage with the IF/ID pipeline register. It holds the PC,
//   issues word fetches over a req/ready handshake, and presents the fetched
//   instruction to decode. It honours decode stalls and branch/jump redirects.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-high reset
//   imem_req       out  1   fetch request (registered)
//   imem_addr      out  32  word-aligned fetch address (registered)
//   imem_rdata     in   32  instruction word, valid with imem_ready
//   imem_ready     in   1   completes the outstanding request this cycle
//   stall          in   1   decode cannot accept; IF/ID holds
//   redirect_valid in   1   taken branch/jump this cycle
//   redirect_pc    in   32  redirect target (low two bits ignored)
//   if_valid       out  1   IF/ID holds a real instruction
//   if_instr       out  32  IF/ID instruction, 0 when invalid
//   if_pc4         out  32  address of if_instr + 4
//   if_opcode      out  6   if_instr[31:26]
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [5:0]  if_opcode
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  // Next fetch address. In DRAIN it carries the pending redirect target
  // while imem_addr stays on the request still in flight.
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  // One-entry skid buffer; it is occupied exactly while in HOLD.
  logic [31:0] r_buf, w_buf_nxt;

  logic [31:0] w_rpc;
  logic [31:0] w_addr_p4;

  assign w_rpc     = redirect_pc & ~32'h0000_0003;
  assign w_addr_p4 = r_addr + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc4   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_valid <= w_valid_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_buf_nxt   = r_buf;

    // A redirect flushes IF/ID regardless of state or stall.
    if (redirect_valid) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = '0;
      w_pc_nxt    = w_rpc;
    end

    unique case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = redirect_valid ? w_rpc : r_pc;
        if (!redirect_valid && !stall) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = '0;
        end
      end

      FETCH: begin
        if (redirect_valid) begin
          if (imem_ready) begin
            w_addr_nxt = w_rpc;
          end else begin
            w_state_nxt = DRAIN;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            w_valid_nxt = 1'b1;
            w_instr_nxt = imem_rdata;
            w_pc4_nxt   = w_addr_p4;
            w_addr_nxt  = w_addr_p4;
            w_pc_nxt    = w_addr_p4;
          end else begin
            w_buf_nxt   = imem_rdata;
            w_req_nxt   = 1'b0;
            w_state_nxt = HOLD;
          end
        end else if (!stall) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = '0;
        end
      end

      HOLD: begin
        // imem_addr still points at the buffered word, so addr+4 is its pc4
        // and also the next fetch address.
        if (redirect_valid) begin
          w_addr_nxt  = w_rpc;
          w_req_nxt   = 1'b1;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_valid_nxt = 1'b1;
          w_instr_nxt = r_buf;
          w_pc4_nxt   = w_addr_p4;
          w_addr_nxt  = w_addr_p4;
          w_pc_nxt    = w_addr_p4;
          w_req_nxt   = 1'b1;
          w_state_nxt = FETCH;
        end
      end

      DRAIN: begin
        // Returning data belongs to the squashed path and is dropped.
        if (imem_ready) begin
          w_addr_nxt  = redirect_valid ? w_rpc : r_pc;
          w_state_nxt = FETCH;
        end
        if (!redirect_valid && !stall) begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = r_valid;
  assign if_instr  = r_instr;
  assign if_pc4    = r_pc4;
  assign if_opcode = r_instr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Bench for fetch_stage. The instruction memory returns addr | 0xA000_0000.
//   Each vector gives the inputs for one cycle and the outputs expected after
//   the following rising edge. If if_valid is expected, if_instr is the word
//   at if_pc4-4. If if_valid is not expected, if_instr must be 0.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  if_opcode;

  localparam logic [31:0] TAG = 32'hA000_0000;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc4         (if_pc4),
    .if_opcode      (if_opcode)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr | TAG;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4;
  } vec_t;

  typedef struct {
    int          id;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic        chk_pc4;
    logic [31:0] pc4;
  } exp_t;

  vec_t tv[28];
  exp_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic s, input logic r, input logic rv,
                              input logic [31:0] rpc, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc4);
    vec_t v;
    v.stall = s; v.ready = r; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc4 = e_pc4;
    return v;
  endfunction

  function automatic exp_t to_exp(input int id, input vec_t v);
    exp_t e;
    e.id      = id;
    e.req     = v.e_req;
    e.addr    = v.e_addr;
    e.valid   = v.e_valid;
    e.instr   = v.e_valid ? ((v.e_pc4 - 32'd4) | TAG) : 32'h0;
    e.chk_pc4 = v.e_valid;
    e.pc4     = v.e_pc4;
    return e;
  endfunction

  task automatic check_head(input string name);
    exp_t  e;
    logic  ok;
    logic [5:0] e_op;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    e_op = e.instr[31:26];
    applied++;
    ok = (imem_req === e.req) && (imem_addr === e.addr) &&
         (if_valid === e.valid) && (if_instr === e.instr) &&
         (if_opcode === e_op) && (!e.chk_pc4 || (if_pc4 === e.pc4));
    if (!ok) begin
      miscompares++;
      $display("FAIL %s #%0d: got req=%b addr=%h valid=%b instr=%h op=%h pc4=%h; want req=%b addr=%h valid=%b instr=%h op=%h pc4=%h(chk=%b)",
               name, e.id, imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc4,
               e.req, e.addr, e.valid, e.instr, e_op, e.pc4, e.chk_pc4);
    end
  endtask

  // Drive one vector, push its expectation, then compare after the edge.
  task automatic apply(input int id, input vec_t v, input string name);
    stall          = v.stall;
    imem_ready     = v.ready;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    sb.push_back(to_exp(id, v));
    @(posedge clk);
    #1;
    check_head(name);
  endtask

  task automatic push_reset_exp(input int id);
    exp_t e;
    e.id = id; e.req = 1'b0; e.addr = 32'h0; e.valid = 1'b0;
    e.instr = 32'h0; e.chk_pc4 = 1'b1; e.pc4 = 32'h0;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             stall rdy rv  rpc            req addr           vld pc4
    tv[0]  = mk(0, 1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0);
    tv[1]  = mk(0, 1, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h0000_0004);
    tv[2]  = mk(0, 1, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h0000_0008);
    tv[3]  = mk(0, 0, 0, 32'h0,          1, 32'h0000_0008, 0, 32'h0);
    tv[4]  = mk(0, 0, 0, 32'h0,          1, 32'h0000_0008, 0, 32'h0);
    tv[5]  = mk(0, 0, 0, 32'h0,          1, 32'h0000_0008, 0, 32'h0);
    tv[6]  = mk(0, 1, 0, 32'h0,          1, 32'h0000_000C, 1, 32'h0000_000C);
    tv[7]  = mk(1, 1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h0000_000C);
    tv[8]  = mk(1, 1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h0000_000C);
    tv[9]  = mk(0, 0, 0, 32'h0,          1, 32'h0000_0010, 1, 32'h0000_0010);
    tv[10] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0014, 1, 32'h0000_0014);
    tv[11] = mk(1, 1, 1, 32'h0000_0043,  1, 32'h0000_0040, 0, 32'h0);
    tv[12] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0044, 1, 32'h0000_0044);
    tv[13] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0048, 1, 32'h0000_0048);
    tv[14] = mk(0, 0, 1, 32'h0000_0080,  1, 32'h0000_0048, 0, 32'h0);
    tv[15] = mk(0, 0, 0, 32'h0,          1, 32'h0000_0048, 0, 32'h0);
    tv[16] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0080, 0, 32'h0);
    tv[17] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0084, 1, 32'h0000_0084);
    tv[18] = mk(0, 0, 1, 32'h0000_0100,  1, 32'h0000_0084, 0, 32'h0);
    tv[19] = mk(0, 0, 1, 32'h0000_0200,  1, 32'h0000_0084, 0, 32'h0);
    tv[20] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0200, 0, 32'h0);
    tv[21] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0204, 1, 32'h0000_0204);
    tv[22] = mk(1, 0, 0, 32'h0,          1, 32'h0000_0204, 1, 32'h0000_0204);
    tv[23] = mk(1, 1, 0, 32'h0,          0, 32'h0000_0204, 1, 32'h0000_0204);
    tv[24] = mk(1, 0, 1, 32'hFFFF_FFFD,  1, 32'hFFFF_FFFC, 0, 32'h0);
    tv[25] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0000, 1, 32'h0000_0000);
    tv[26] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h0000_0004);
    tv[27] = mk(1, 1, 0, 32'h0,          0, 32'h0000_0004, 1, 32'h0000_0004);

    reset          = 1'b1;
    stall          = 1'b0;
    imem_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    push_reset_exp(100);
    check_head("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      apply(i, tv[i], "vector");
    end

    // Asynchronous reset in the middle of HOLD, with no clock edge in between.
    #2;
    reset = 1'b1;
    #1;
    push_reset_exp(200);
    check_head("async_reset_mid_hold");

    // Release, then check the first-fetch latency from a fresh reset.
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(300, mk(0, 1, 0, 32'h0, 1, 32'h0000_0000, 0, 32'h0), "post_reset_req");
    apply(301, mk(0, 1, 0, 32'h0, 1, 32'h0000_0004, 1, 32'h0000_0004), "post_reset_first");
    apply(302, mk(0, 1, 0, 32'h0, 1, 32'h0000_0008, 1, 32'h0000_0008), "post_reset_second");

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
